mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV64 pipeline.
- Sits between the EX/MEM pipeline register (upstream) and the MEM/WB register (downstream).
- Consumes the EX/MEM outputs and drives load/store requests on a request/grant/response data bus.
- Sign/zero-extends load data, generates byte strobes for stores, and presents one registered result per instruction to writeback under a valid/ready handshake.

Parameters:
- ADDR_W, 64, data-bus address width.
- DATA_W, 64, register/data-bus width; byte strobe width is DATA_W/8.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard the held instruction and the output slot.
- ex_valid  in  1  upstream holds a valid instruction.
- mem_ready  out  1  stage can accept an instruction this cycle.
- in_w_ena / in_w_addr / in_w_data  in  1/5/64  regfile write info from EX/MEM.
- in_memwop / in_memrop  in  3/3  store/load op codes.
- in_mem_ena / in_mem_wr  in  1/1  memory access enable; 1 = write.
- in_mem_addr / in_stor_data  in  64/64  byte address; store data.
- in_pc / in_instr  in  64/32  tracking info.
- dbus_req  out  1  bus request, held until granted.
- dbus_wr  out  1  1 = store.
- dbus_addr  out  64  in_mem_addr with bits[2:0] cleared.
- dbus_wdata  out  64  store data shifted to byte lane.
- dbus_wstrb  out  8  byte enables (0 for loads).
- dbus_gnt  in  1  request accepted.
- dbus_rvalid  in  1  response (load data or store ack).
- dbus_rdata  in  64  aligned 8-byte read data.
- wb_valid  out  1  result valid toward MEM/WB.
- wb_ready  in  1  downstream accepts.
- wb_w_ena / wb_w_addr / wb_w_data  out  1/5/64  writeback result.
- wb_pc / wb_instr  out  64/32  tracking info.
- misalign  out  1  one-cycle pulse: misaligned access dropped.

Behaviour:
- Op codes (memrop): 0 none, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU. memwop uses 0 none, 1 SB, 2 SH, 3 SW, 4 SD; memwop values 5–7 are treated as none.
- Acceptance: mem_ready = (state==IDLE) & (!wb_valid | wb_ready). An instruction is accepted when ex_valid & mem_ready.
- FSM states: IDLE, REQ, WAIT.
  - IDLE with accepted non-memory instruction (in_mem_ena=0): load output slot next cycle; latency 1 cycle.
  - IDLE with accepted aligned memory instruction: latch the instruction, go to REQ.
  - REQ: drive dbus_req with address/strobes. dbus_gnt -> WAIT. If dbus_gnt and dbus_rvalid arrive in the same cycle, complete directly.
  - WAIT: on dbus_rvalid, load output slot and go to IDLE.
  - Minimum memory latency: 2 cycles (accept -> wb_valid).
- Alignment: access size is 1, 2, 4 or 8 bytes. An address not a multiple of the size issues no bus request, pulses misalign, and produces an output with wb_w_ena=0.
- Load result: select the byte lane at addr[2:0] from dbus_rdata, then sign- or zero-extend to 64 bits. Loads write wb_w_data = extended data. Stores and non-memory ops pass in_w_data.
- Store: wdata = stor_data << (8*addr[2:0]); wstrb = size mask << addr[2:0].
- Output slot: wb_* are registered. The slot clears (wb_valid=0) when wb_ready while no new result is loaded. The slot holds unchanged while wb_valid & !wb_ready.
- flush:
  - Clears wb_valid and drops the instruction being accepted that cycle.
  - In REQ without grant: deassert dbus_req next cycle, go to IDLE.
  - In REQ with grant, or in WAIT: enter WAIT-discard. Consume the pending dbus_rvalid without writing the slot, then go to IDLE. mem_ready stays 0 until then.
- Reset (also mid-transaction): state=IDLE, dbus_req=0, dbus_wr=0, dbus_wstrb=0, wb_valid=0, wb_w_ena=0, wb_w_addr=0, wb_w_data=0, wb_pc=0, wb_instr=0x00000013 (NOP), misalign=0. In-flight bus responses after reset are ignored.
- wb_w_addr==0 passes through unchanged; the regfile ignores x0.

Test Plan:
- Non-memory ADD: in_w_data=0x5 to x3 -> next cycle wb_valid=1, wb_w_addr=3, wb_w_data=0x5, no dbus_req.
- LB at 0x8003, rdata=0x0000_0000_80FF_0000, gnt at cycle 1, rvalid at cycle 3 -> wb_w_data=0xFFFF_FFFF_FFFF_FF80. The same access as LBU -> 0x80.
- SH 0xBEEF at 0x1006 -> dbus_addr=0x1000, dbus_wstrb=0xC0, dbus_wdata=0xBEEF_0000_0000_0000, wb_w_ena=0.
- LW at 0x1002 -> no dbus_req, misalign pulse, wb_valid=1 with wb_w_ena=0.
- Backpressure: wb_ready=0 while a result is held -> mem_ready=0, wb_* stable; wb_ready=1 -> the next instruction is accepted the same cycle.
- flush in WAIT, then rvalid -> no wb_valid, state IDLE, mem_ready=1 the following cycle. Reset during REQ -> dbus_req=0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM loads/stores into dbus transactions and registers one result per instruction.
// Latency: 1 cycle (accept -> wb_valid) for non-memory/misaligned ops, >= 2 cycles for bus accesses.
// Backpressure: mem_ready drops while a bus access is outstanding or a held result is not taken by wb_ready.
module mem_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              mem_ready,
  input  logic              in_w_ena,
  input  logic [4:0]        in_w_addr,
  input  logic [DATA_W-1:0] in_w_data,
  input  logic [2:0]        in_memwop,
  input  logic [2:0]        in_memrop,
  input  logic              in_mem_ena,
  input  logic              in_mem_wr,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [DATA_W-1:0] in_stor_data,
  input  logic [63:0]       in_pc,
  input  logic [31:0]       in_instr,
  output logic              dbus_req,
  output logic              dbus_wr,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [DATA_W-1:0] dbus_wdata,
  output logic [DATA_W/8-1:0] dbus_wstrb,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_w_ena,
  output logic [4:0]        wb_w_addr,
  output logic [DATA_W-1:0] wb_w_data,
  output logic [63:0]       wb_pc,
  output logic [31:0]       wb_instr,
  output logic              misalign
);

  localparam int          STRB_W    = DATA_W / 8;
  localparam int          OFF_W     = $clog2(STRB_W);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // S_DRAIN waits for the response of a flushed access and throws it away.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
  state_t state_q, state_d;

  // latched memory instruction
  logic              w_ena_q;
  logic [4:0]        w_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic              wr_q;
  logic [2:0]        rop_q;
  logic [OFF_W-1:0]  off_q;
  logic [63:0]       pc_q;
  logic [31:0]       instr_q;

  // bus request registers
  logic              dbus_wr_q;
  logic [ADDR_W-1:0] dbus_addr_q;
  logic [DATA_W-1:0] dbus_wdata_q;
  logic [STRB_W-1:0] dbus_wstrb_q;

  // output slot
  logic              wb_valid_q, wb_valid_d;
  logic              wb_w_ena_q, wb_w_ena_d;
  logic [4:0]        wb_w_addr_q, wb_w_addr_d;
  logic [DATA_W-1:0] wb_w_data_q, wb_w_data_d;
  logic [63:0]       wb_pc_q, wb_pc_d;
  logic [31:0]       wb_instr_q, wb_instr_d;
  logic              misalign_q, misalign_d;

  logic              acc_vld_c;
  logic [1:0]        acc_lg_c;
  logic [STRB_W-1:0] size_mask_c;
  logic [OFF_W-1:0]  align_mask_c;
  logic [OFF_W-1:0]  off_c;
  logic              misal_c;
  logic              is_mem_c;
  logic              accept_c;
  logic              issue_c;
  logic              done_c;
  logic [DATA_W-1:0] lane_c;
  logic [DATA_W-1:0] ld_data_c;

  // Decode access size (log2 bytes); unused op codes mean "no access".
  always_comb begin
    acc_vld_c = 1'b1;
    acc_lg_c  = 2'd0;
    if (in_mem_wr) begin
      case (in_memwop)
        3'd1:    acc_lg_c = 2'd0;
        3'd2:    acc_lg_c = 2'd1;
        3'd3:    acc_lg_c = 2'd2;
        3'd4:    acc_lg_c = 2'd3;
        default: acc_vld_c = 1'b0;
      endcase
    end else begin
      case (in_memrop)
        3'd1, 3'd5: acc_lg_c = 2'd0;
        3'd2, 3'd6: acc_lg_c = 2'd1;
        3'd3, 3'd7: acc_lg_c = 2'd2;
        3'd4:       acc_lg_c = 2'd3;
        default:    acc_vld_c = 1'b0;
      endcase
    end
  end

  // Byte-enable pattern and the low address bits that must be zero for this size.
  always_comb begin
    size_mask_c  = STRB_W'(8'hFF);
    align_mask_c = OFF_W'(3'd7);
    case (acc_lg_c)
      2'd0: begin size_mask_c = STRB_W'(8'h01); align_mask_c = OFF_W'(3'd0); end
      2'd1: begin size_mask_c = STRB_W'(8'h03); align_mask_c = OFF_W'(3'd1); end
      2'd2: begin size_mask_c = STRB_W'(8'h0F); align_mask_c = OFF_W'(3'd3); end
      default: ;
    endcase
  end

  assign off_c     = in_mem_addr[OFF_W-1:0];
  assign misal_c   = |(off_c & align_mask_c);
  assign is_mem_c  = in_mem_ena & acc_vld_c;
  assign mem_ready = (state_q == S_IDLE) & (~wb_valid_q | wb_ready);
  assign accept_c  = ex_valid & mem_ready & ~flush;
  assign issue_c   = accept_c & is_mem_c & ~misal_c;

  // Pick the addressed lane out of the aligned word and extend it.
  always_comb begin
    lane_c    = dbus_rdata >> {off_q, 3'b000};
    ld_data_c = lane_c;
    case (rop_q)
      3'd1: ld_data_c = {{(DATA_W-8){lane_c[7]}},   lane_c[7:0]};
      3'd2: ld_data_c = {{(DATA_W-16){lane_c[15]}}, lane_c[15:0]};
      3'd3: ld_data_c = {{(DATA_W-32){lane_c[31]}}, lane_c[31:0]};
      3'd5: ld_data_c = {{(DATA_W-8){1'b0}},        lane_c[7:0]};
      3'd6: ld_data_c = {{(DATA_W-16){1'b0}},       lane_c[15:0]};
      3'd7: ld_data_c = {{(DATA_W-32){1'b0}},       lane_c[31:0]};
      default: ;
    endcase
  end

  // Bus sequencing; a flush after grant still has to swallow the response.
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_c) state_d = S_REQ;
      end
      S_REQ: begin
        if (dbus_gnt) begin
          if (dbus_rvalid) begin
            state_d = S_IDLE;
            done_c  = ~flush;
          end else begin
            state_d = flush ? S_DRAIN : S_WAIT;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dbus_rvalid) begin
          state_d = S_IDLE;
          done_c  = ~flush;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dbus_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output slot: hold while stalled, clear when taken, load on a new result.
  always_comb begin
    wb_valid_d  = wb_valid_q & ~wb_ready;
    wb_w_ena_d  = wb_w_ena_q;
    wb_w_addr_d = wb_w_addr_q;
    wb_w_data_d = wb_w_data_q;
    wb_pc_d     = wb_pc_q;
    wb_instr_d  = wb_instr_q;
    misalign_d  = accept_c & is_mem_c & misal_c;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (accept_c && !issue_c) begin
      wb_valid_d  = 1'b1;
      wb_w_ena_d  = is_mem_c ? 1'b0 : in_w_ena;
      wb_w_addr_d = in_w_addr;
      wb_w_data_d = in_w_data;
      wb_pc_d     = in_pc;
      wb_instr_d  = in_instr;
    end else if (done_c) begin
      wb_valid_d  = 1'b1;
      wb_w_ena_d  = wr_q ? 1'b0 : w_ena_q;
      wb_w_addr_d = w_addr_q;
      wb_w_data_d = wr_q ? w_data_q : ld_data_c;
      wb_pc_d     = pc_q;
      wb_instr_d  = instr_q;
    end
  end

  // State and output slot registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wb_valid_q  <= 1'b0;
      wb_w_ena_q  <= 1'b0;
      wb_w_addr_q <= '0;
      wb_w_data_q <= '0;
      wb_pc_q     <= '0;
      wb_instr_q  <= NOP_INSTR;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_w_ena_q  <= wb_w_ena_d;
      wb_w_addr_q <= wb_w_addr_d;
      wb_w_data_q <= wb_w_data_d;
      wb_pc_q     <= wb_pc_d;
      wb_instr_q  <= wb_instr_d;
      misalign_q  <= misalign_d;
    end
  end

  // Capture the memory instruction and its bus request when it is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      dbus_wr_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_wdata_q <= '0;
      dbus_wstrb_q <= '0;
      w_ena_q      <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      wr_q         <= 1'b0;
      rop_q        <= '0;
      off_q        <= '0;
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
    end else if (issue_c) begin
      dbus_wr_q    <= in_mem_wr;
      dbus_addr_q  <= {in_mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      dbus_wdata_q <= in_stor_data << {off_c, 3'b000};
      dbus_wstrb_q <= in_mem_wr ? (size_mask_c << off_c) : '0;
      w_ena_q      <= in_w_ena;
      w_addr_q     <= in_w_addr;
      w_data_q     <= in_w_data;
      wr_q         <= in_mem_wr;
      rop_q        <= in_memrop;
      off_q        <= off_c;
      pc_q         <= in_pc;
      instr_q      <= in_instr;
    end
  end

  assign dbus_req   = (state_q == S_REQ);
  assign dbus_wr    = dbus_wr_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_wdata = dbus_wdata_q;
  assign dbus_wstrb = dbus_wstrb_q;

  assign wb_valid  = wb_valid_q;
  assign wb_w_ena  = wb_w_ena_q;
  assign wb_w_addr = wb_w_addr_q;
  assign wb_w_data = wb_w_data_q;
  assign wb_pc     = wb_pc_q;
  assign wb_instr  = wb_instr_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single instructions plus
// hand sequences for split grant/response, backpressure, flush and reset.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset, flush, ex_valid, mem_ready;
  logic        in_w_ena;
  logic [4:0]  in_w_addr;
  logic [63:0] in_w_data;
  logic [2:0]  in_memwop, in_memrop;
  logic        in_mem_ena, in_mem_wr;
  logic [63:0] in_mem_addr, in_stor_data, in_pc;
  logic [31:0] in_instr;
  logic        dbus_req, dbus_wr, dbus_gnt, dbus_rvalid;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]  dbus_wstrb;
  logic        wb_valid, wb_ready, wb_w_ena, misalign;
  logic [4:0]  wb_w_addr;
  logic [63:0] wb_w_data, wb_pc;
  logic [31:0] wb_instr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .mem_ready(mem_ready),
    .in_w_ena(in_w_ena), .in_w_addr(in_w_addr), .in_w_data(in_w_data),
    .in_memwop(in_memwop), .in_memrop(in_memrop),
    .in_mem_ena(in_mem_ena), .in_mem_wr(in_mem_wr),
    .in_mem_addr(in_mem_addr), .in_stor_data(in_stor_data),
    .in_pc(in_pc), .in_instr(in_instr),
    .dbus_req(dbus_req), .dbus_wr(dbus_wr), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
    .wb_pc(wb_pc), .wb_instr(wb_instr), .misalign(misalign)
  );

  typedef struct {
    logic        mem_ena;
    logic        mem_wr;
    logic [2:0]  wop;
    logic [2:0]  rop;
    logic        w_ena;
    logic [4:0]  w_addr;
    logic [63:0] w_data;
    logic [63:0] addr;
    logic [63:0] stor;
    logic [63:0] rdata;
    logic        e_bus;
    logic        e_misal;
    logic        e_w_ena;
    logic [7:0]  e_wstrb;
    logic [63:0] e_wdata;
    logic [63:0] e_data;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; ex_valid = 0; in_w_ena = 0; in_w_addr = 0; in_w_data = 0;
    in_memwop = 0; in_memrop = 0; in_mem_ena = 0; in_mem_wr = 0;
    in_mem_addr = 0; in_stor_data = 0; in_pc = 0; in_instr = 32'h13;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
  endtask

  task automatic drive(input logic mem_ena, input logic mem_wr, input logic [2:0] wop,
                       input logic [2:0] rop, input logic w_ena, input logic [4:0] w_addr,
                       input logic [63:0] w_data, input logic [63:0] addr,
                       input logic [63:0] stor, input logic [63:0] pc);
    ex_valid = 1; in_mem_ena = mem_ena; in_mem_wr = mem_wr; in_memwop = wop;
    in_memrop = rop; in_w_ena = w_ena; in_w_addr = w_addr; in_w_data = w_data;
    in_mem_addr = addr; in_stor_data = stor; in_pc = pc; in_instr = pc[31:0] ^ 32'h33;
  endtask

  // LB/LBU at 0x8003 with grant one cycle after accept and response two cycles later.
  task automatic lb_seq(input logic [2:0] rop, input logic [63:0] exp);
    drive(1, 0, 3'd0, rop, 1, 5'd9, 64'h0, 64'h8003, 64'h0, 64'h900);
    tick();
    ex_valid = 0;
    chk("lb_req", dbus_req, 1);
    chk("lb_addr", dbus_addr, 64'h8000);
    chk("lb_wstrb", dbus_wstrb, 0);
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0;
    #1;
    chk("lb_req_drop", dbus_req, 0);
    chk("lb_busy", mem_ready, 0);
    tick();
    chk("lb_no_early", wb_valid, 0);
    dbus_rvalid = 1; dbus_rdata = 64'h0000_0000_80FF_0000;
    tick();
    dbus_rvalid = 0;
    chk("lb_valid", wb_valid, 1);
    chk("lb_data", wb_w_data, exp);
    chk("lb_waddr", wb_w_addr, 9);
    chk("lb_wena", wb_w_ena, 1);
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          mem wr  wop   rop   wen wad    w_data   addr          stor                    rdata                    bus mis wen wstrb  e_wdata                  e_data
    tbl[0]  = '{0, 0, 3'd0, 3'd0, 1, 5'd3,  64'h5,    64'h0,    64'h0,                  64'h0,                   0, 0, 1, 8'h00, 64'h0,                   64'h5};
    tbl[1]  = '{0, 0, 3'd0, 3'd0, 1, 5'd0,  64'h1234, 64'h0,    64'h0,                  64'h0,                   0, 0, 1, 8'h00, 64'h0,                   64'h1234};
    tbl[2]  = '{1, 0, 3'd0, 3'd3, 1, 5'd7,  64'hAA,   64'h1002, 64'h0,                  64'h0,                   0, 1, 0, 8'h00, 64'h0,                   64'h0};
    tbl[3]  = '{1, 1, 3'd4, 3'd0, 0, 5'd0,  64'h0,    64'h2004, 64'h55,                 64'h0,                   0, 1, 0, 8'h00, 64'h0,                   64'h0};
    tbl[4]  = '{1, 0, 3'd0, 3'd2, 1, 5'd8,  64'h0,    64'h3001, 64'h0,                  64'h0,                   0, 1, 0, 8'h00, 64'h0,                   64'h0};
    tbl[5]  = '{1, 0, 3'd0, 3'd4, 1, 5'd10, 64'h0,    64'h4000, 64'h0,                  64'h0123_4567_89AB_CDEF, 1, 0, 1, 8'h00, 64'h0,                   64'h0123_4567_89AB_CDEF};
    tbl[6]  = '{1, 0, 3'd0, 3'd2, 1, 5'd11, 64'h0,    64'h4006, 64'h0,                  64'h8001_0000_0000_0000, 1, 0, 1, 8'h00, 64'h0,                   64'hFFFF_FFFF_FFFF_8001};
    tbl[7]  = '{1, 0, 3'd0, 3'd6, 1, 5'd11, 64'h0,    64'h4006, 64'h0,                  64'h8001_0000_0000_0000, 1, 0, 1, 8'h00, 64'h0,                   64'h8001};
    tbl[8]  = '{1, 0, 3'd0, 3'd3, 1, 5'd12, 64'h0,    64'h4004, 64'h0,                  64'h8765_4321_0000_0000, 1, 0, 1, 8'h00, 64'h0,                   64'hFFFF_FFFF_8765_4321};
    tbl[9]  = '{1, 0, 3'd0, 3'd7, 1, 5'd12, 64'h0,    64'h4004, 64'h0,                  64'h8765_4321_0000_0000, 1, 0, 1, 8'h00, 64'h0,                   64'h8765_4321};
    tbl[10] = '{1, 0, 3'd0, 3'd1, 1, 5'd14, 64'h0,    64'h4001, 64'h0,                  64'h7F00,                1, 0, 1, 8'h00, 64'h0,                   64'h7F};
    tbl[11] = '{1, 1, 3'd1, 3'd0, 0, 5'd0,  64'h77,   64'h5003, 64'h1122_33AB,          64'h0,                   1, 0, 0, 8'h08, 64'h0011_2233_AB00_0000, 64'h77};
    tbl[12] = '{1, 1, 3'd3, 3'd0, 0, 5'd0,  64'h77,   64'h5004, 64'hDEAD_BEEF,          64'h0,                   1, 0, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h77};
    tbl[13] = '{1, 1, 3'd4, 3'd0, 0, 5'd0,  64'h77,   64'h5008, 64'h0102_0304_0506_0708, 64'h0,                  1, 0, 0, 8'hFF, 64'h0102_0304_0506_0708, 64'h77};
    tbl[14] = '{1, 1, 3'd2, 3'd0, 0, 5'd0,  64'h77,   64'h1006, 64'hBEEF,               64'h0,                   1, 0, 0, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h77};

    clear_inputs();
    wb_ready = 1;
    reset = 1;
    tick();
    tick();
    chk("rst_req", dbus_req, 0);
    chk("rst_wr", dbus_wr, 0);
    chk("rst_wstrb", dbus_wstrb, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_wena", wb_w_ena, 0);
    chk("rst_waddr", wb_w_addr, 0);
    chk("rst_wdata", wb_w_data, 0);
    chk("rst_pc", wb_pc, 0);
    chk("rst_instr", wb_instr, 64'h13);
    chk("rst_misal", misalign, 0);
    reset = 0;
    #1;
    chk("rst_ready", mem_ready, 1);

    // table: each vector is one instruction; bus accesses complete with grant+response together
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].mem_ena, tbl[i].mem_wr, tbl[i].wop, tbl[i].rop, tbl[i].w_ena,
            tbl[i].w_addr, tbl[i].w_data, tbl[i].addr, tbl[i].stor, 64'h8000_0000 + 64'(i * 4));
      tick();
      ex_valid = 0;
      if (tbl[i].e_bus) begin
        chk($sformatf("v%0d_req", i), dbus_req, 1);
        chk($sformatf("v%0d_addr", i), dbus_addr, tbl[i].addr & ~64'h7);
        chk($sformatf("v%0d_wr", i), dbus_wr, tbl[i].mem_wr);
        chk($sformatf("v%0d_wstrb", i), dbus_wstrb, tbl[i].e_wstrb);
        if (tbl[i].mem_wr) chk($sformatf("v%0d_wdata", i), dbus_wdata, tbl[i].e_wdata);
        chk($sformatf("v%0d_early", i), wb_valid, 0);
        dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = tbl[i].rdata;
        tick();
        dbus_gnt = 0; dbus_rvalid = 0;
      end else begin
        chk($sformatf("v%0d_noreq", i), dbus_req, 0);
      end
      chk($sformatf("v%0d_valid", i), wb_valid, 1);
      chk($sformatf("v%0d_misal", i), misalign, tbl[i].e_misal);
      chk($sformatf("v%0d_wena", i), wb_w_ena, tbl[i].e_w_ena);
      chk($sformatf("v%0d_waddr", i), wb_w_addr, tbl[i].w_addr);
      chk($sformatf("v%0d_pc", i), wb_pc, 64'h8000_0000 + 64'(i * 4));
      if (!tbl[i].e_misal) chk($sformatf("v%0d_data", i), wb_w_data, tbl[i].e_data);
      tick();
      chk($sformatf("v%0d_clear", i), wb_valid, 0);
      chk($sformatf("v%0d_pulse", i), misalign, 0);
      chk($sformatf("v%0d_idle", i), dbus_req, 0);
    end

    // split grant / response timing
    lb_seq(3'd1, 64'hFFFF_FFFF_FFFF_FF80);
    lb_seq(3'd5, 64'h80);

    // backpressure: result held, next instruction waits, then passes in the release cycle
    wb_ready = 0;
    drive(0, 0, 3'd0, 3'd0, 1, 5'd4, 64'h11, 64'h0, 64'h0, 64'hA00);
    tick();
    drive(0, 0, 3'd0, 3'd0, 1, 5'd5, 64'h22, 64'h0, 64'h0, 64'hA04);
    #1;
    chk("bp_ready", mem_ready, 0);
    tick();
    chk("bp_hold_valid", wb_valid, 1);
    chk("bp_hold_addr", wb_w_addr, 4);
    chk("bp_hold_data", wb_w_data, 64'h11);
    wb_ready = 1;
    #1;
    chk("bp_release_ready", mem_ready, 1);
    tick();
    ex_valid = 0;
    chk("bp_next_valid", wb_valid, 1);
    chk("bp_next_addr", wb_w_addr, 5);
    chk("bp_next_data", wb_w_data, 64'h22);
    tick();
    chk("bp_drained", wb_valid, 0);

    // flush drops the held result and the instruction offered in the same cycle
    wb_ready = 0;
    drive(0, 0, 3'd0, 3'd0, 1, 5'd6, 64'h33, 64'h0, 64'h0, 64'hB00);
    tick();
    drive(0, 0, 3'd0, 3'd0, 1, 5'd7, 64'h44, 64'h0, 64'h0, 64'hB04);
    wb_ready = 1; flush = 1;
    tick();
    ex_valid = 0; flush = 0;
    chk("fl_slot_clear", wb_valid, 0);
    tick();
    chk("fl_dropped", wb_valid, 0);

    // flush while waiting for the response: response is swallowed
    drive(1, 0, 3'd0, 3'd4, 1, 5'd8, 64'h0, 64'h6000, 64'h0, 64'hC00);
    tick();
    ex_valid = 0;
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0; flush = 1;
    tick();
    flush = 0;
    #1;
    chk("fw_busy", mem_ready, 0);
    dbus_rvalid = 1; dbus_rdata = 64'hDEAD;
    tick();
    dbus_rvalid = 0;
    #1;
    chk("fw_no_valid", wb_valid, 0);
    chk("fw_ready", mem_ready, 1);
    chk("fw_no_req", dbus_req, 0);

    // reset in the middle of a request, then a stray response
    drive(1, 0, 3'd0, 3'd3, 1, 5'd9, 64'h0, 64'h7000, 64'h0, 64'hD00);
    tick();
    ex_valid = 0;
    chk("rr_req", dbus_req, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rr_req_drop", dbus_req, 0);
    chk("rr_instr", wb_instr, 64'h13);
    dbus_rvalid = 1; dbus_rdata = 64'h1234;
    tick();
    dbus_rvalid = 0;
    chk("rr_stray", wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
